i2c_apb_sequencer: RTL and testbench

APB master that sequences the I2C core's APB register file (transmit, receive, slave address, command, prescale, status) on behalf of a simple job interface. A host issues one job: rw, 7-bit address, prescale and byte count. The block performs the register writes, polls status and streams receive bytes back. It sits between system control logic and the I2C core's APB slave port, on the same pclk domain.

---
 rtl/i2c_apb_pkg.sv | 52 +++++
 rtl/apb_master_xfer.sv | 62 ++++++
 rtl/i2c_apb_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_i2c_apb_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_apb_pkg
//  Description : Shared definitions for the I2C APB sequencer: register map of
//                the I2C core, STATUS/COMMAND bit positions, sequencer state
//                encoding and a COMMAND byte builder.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_apb_pkg;

   // I2C core APB register map
   localparam int unsigned c_reg_transmit   = 0;
   localparam int unsigned c_reg_receive    = 1;
   localparam int unsigned c_reg_slave_addr = 2;
   localparam int unsigned c_reg_command    = 3;
   localparam int unsigned c_reg_prescale   = 4;
   localparam int unsigned c_reg_status     = 5;

   // STATUS register bits
   localparam int unsigned c_stat_busy = 7;
   localparam int unsigned c_stat_nack = 6;

   // COMMAND register bits
   localparam int unsigned c_cmd_start = 0;
   localparam int unsigned c_cmd_rw    = 1;
   localparam int unsigned c_cmd_stop  = 2;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_CFG_PRESC = 4'd1,
      ST_CFG_ADDR  = 4'd2,
      ST_WAIT_TX   = 4'd3,
      ST_WR_DATA   = 4'd4,
      ST_WR_CMD    = 4'd5,
      ST_POLL      = 4'd6,
      ST_RD_DATA   = 4'd7,
      ST_DONE      = 4'd8
   } seq_state_t;

   // COMMAND byte: START always set, RW follows the job, STOP on the last byte
   function automatic logic [7:0] make_cmd(input logic last, input logic rw);
      logic [7:0] cmd;
      cmd              = 8'h00;
      cmd[c_cmd_start] = 1'b1;
      cmd[c_cmd_rw]    = rw;
      cmd[c_cmd_stop]  = last;
      return cmd;
   endfunction

endpackage
`default_nettype wire

// File: rtl/apb_master_xfer.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_xfer
//  Description : Single APB transfer engine. While i_start is held the pins
//                run SETUP (first cycle) then ACCESS until i_pready; o_done is
//                high in the completing cycle. Dropping i_start on the cycle
//                after completion is not needed: holding it starts the next
//                transfer's SETUP immediately.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                i_start             - transfer request (held until o_done)
//                i_addr/i_write/i_wdata - transfer attributes
//                o_done/o_rdata      - completion strobe and read data
//                o_p*/i_prdata/i_pready - APB master pins
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_master_xfer #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic                  i_write,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   output logic                  o_done,
   output logic [DATA_WIDTH-1:0] o_rdata,
   output logic [ADDR_WIDTH-1:0] o_paddr,
   output logic                  o_pwrite,
   output logic                  o_psel,
   output logic                  o_penable,
   output logic [DATA_WIDTH-1:0] o_pwdata,
   input  logic [DATA_WIDTH-1:0] i_prdata,
   input  logic                  i_pready
);

   logic r_access;
   logic w_done;

   assign w_done = i_start & r_access & i_pready;

   // ACCESS follows SETUP; after completion fall back to SETUP so a held
   // request issues back-to-back transfers with no idle cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_access <= 1'b0;
      end else begin
         r_access <= i_start & ~w_done;
      end
   end

   // Pins are zero whenever no transfer is requested.
   assign o_psel    = i_start;
   assign o_penable = i_start & r_access;
   assign o_paddr   = i_start ? i_addr : '0;
   assign o_pwrite  = i_start & i_write;
   assign o_pwdata  = (i_start & i_write) ? i_wdata : '0;
   assign o_done    = w_done;
   assign o_rdata   = i_prdata;

endmodule
`default_nettype wire

// File: rtl/i2c_apb_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_apb_sequencer
//  Description : APB master that runs one I2C job against the I2C core's
//                register file: programs PRESCALE and SLAVE_ADDR, then per
//                byte writes TRANSMIT (write jobs), COMMAND, polls STATUS and
//                reads RECEIVE (read jobs).
//  Ports       : pclk_i, preset_i           - clock, sync active-high reset
//                job_*                      - job request handshake/fields
//                tx_valid_i/tx_ready_o/tx_data_i - write byte stream
//                rx_valid_o/rx_data_o       - read byte strobe
//                done_o/error_o             - job completion and status
//                paddr_o..pready_i          - APB master port
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_apb_sequencer
   import i2c_apb_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 4,
   parameter int POLL_MAX   = 255
) (
   input  logic                  pclk_i,
   input  logic                  preset_i,
   input  logic                  job_valid_i,
   output logic                  job_ready_o,
   input  logic                  job_rw_i,
   input  logic [6:0]            job_addr_i,
   input  logic [7:0]            job_prescale_i,
   input  logic [LEN_WIDTH-1:0]  job_len_i,
   input  logic                  tx_valid_i,
   output logic                  tx_ready_o,
   input  logic [7:0]            tx_data_i,
   output logic                  rx_valid_o,
   output logic [7:0]            rx_data_o,
   output logic                  done_o,
   output logic                  error_o,
   output logic [ADDR_WIDTH-1:0] paddr_o,
   output logic                  pwrite_o,
   output logic                  psel_o,
   output logic                  penable_o,
   output logic [DATA_WIDTH-1:0] pwdata_o,
   input  logic [DATA_WIDTH-1:0] prdata_i,
   input  logic                  pready_i
);

   // Counter holds 0..POLL_MAX-1; the POLL_MAX-th busy read ends the job.
   localparam int c_poll_w = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;

   seq_state_t r_state;
   seq_state_t w_next;

   logic                  r_rw;
   logic [6:0]            r_addr;
   logic [7:0]            r_presc;
   logic [LEN_WIDTH-1:0]  r_remain;
   logic [7:0]            r_tx_byte;
   logic [c_poll_w-1:0]   r_poll_cnt;
   logic                  r_err;
   logic [7:0]            r_rx_data;
   logic                  r_rx_valid;

   logic                  w_start;
   logic                  w_write;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic                  w_done;
   logic [DATA_WIDTH-1:0] w_rdata;
   logic                  w_last;
   logic                  w_busy;
   logic                  w_nack;
   logic                  w_poll_exp;

   assign w_last     = (r_remain == LEN_WIDTH'(1));
   assign w_busy     = w_rdata[c_stat_busy];
   assign w_nack     = w_rdata[c_stat_nack];
   assign w_poll_exp = (r_poll_cnt == c_poll_w'(POLL_MAX - 1));

   apb_master_xfer #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_xfer (
      .clk       (pclk_i),
      .rst       (preset_i),
      .i_start   (w_start),
      .i_addr    (w_addr),
      .i_write   (w_write),
      .i_wdata   (w_wdata),
      .o_done    (w_done),
      .o_rdata   (w_rdata),
      .o_paddr   (paddr_o),
      .o_pwrite  (pwrite_o),
      .o_psel    (psel_o),
      .o_penable (penable_o),
      .o_pwdata  (pwdata_o),
      .i_prdata  (prdata_i),
      .i_pready  (pready_i)
   );

   // ---------------------------------------------------------------- state
   always_ff @(posedge pclk_i) begin
      if (preset_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ------------------------------------------------------------ next state
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:      if (job_valid_i) w_next = ST_CFG_PRESC;
         ST_CFG_PRESC: if (w_done) w_next = ST_CFG_ADDR;
         ST_CFG_ADDR: begin
            if (w_done) begin
               if (r_remain == '0) w_next = ST_DONE;
               else if (r_rw)      w_next = ST_WR_CMD;
               else                w_next = ST_WAIT_TX;
            end
         end
         ST_WAIT_TX:   if (tx_valid_i) w_next = ST_WR_DATA;
         ST_WR_DATA:   if (w_done) w_next = ST_WR_CMD;
         ST_WR_CMD:    if (w_done) w_next = ST_POLL;
         ST_POLL: begin
            if (w_done) begin
               if (w_busy) begin
                  if (w_poll_exp) w_next = ST_DONE;
               end else if (w_nack) begin
                  w_next = ST_DONE;
               end else if (r_rw) begin
                  w_next = ST_RD_DATA;
               end else begin
                  w_next = w_last ? ST_DONE : ST_WAIT_TX;
               end
            end
         end
         ST_RD_DATA:   if (w_done) w_next = w_last ? ST_DONE : ST_WR_CMD;
         ST_DONE:      w_next = ST_IDLE;
         default:      w_next = ST_IDLE;
      endcase
   end

   // -------------------------------------------------------------- datapath
   always_ff @(posedge pclk_i) begin
      if (preset_i) begin
         r_rw       <= 1'b0;
         r_addr     <= '0;
         r_presc    <= '0;
         r_remain   <= '0;
         r_tx_byte  <= '0;
         r_poll_cnt <= '0;
         r_err      <= 1'b0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (job_valid_i) begin
                  r_rw     <= job_rw_i;
                  r_addr   <= job_addr_i;
                  r_presc  <= job_prescale_i;
                  r_remain <= job_len_i;
                  r_err    <= 1'b0;
               end
            end
            ST_WAIT_TX: if (tx_valid_i) r_tx_byte <= tx_data_i;
            ST_WR_CMD:  r_poll_cnt <= '0;
            ST_POLL: begin
               if (w_done) begin
                  if (w_busy) begin
                     if (w_poll_exp) r_err <= 1'b1;
                     else            r_poll_cnt <= r_poll_cnt + c_poll_w'(1);
                  end else if (w_nack) begin
                     r_err <= 1'b1;
                  end else if (!r_rw && !w_last) begin
                     // write byte acknowledged; reads count down after RECEIVE
                     r_remain <= r_remain - LEN_WIDTH'(1);
                  end
               end
            end
            ST_RD_DATA: begin
               if (w_done) begin
                  r_rx_data  <= w_rdata[7:0];
                  r_rx_valid <= 1'b1;
                  if (!w_last) r_remain <= r_remain - LEN_WIDTH'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // --------------------------------------------------------------- outputs
   always_comb begin
      w_start     = 1'b0;
      w_write     = 1'b0;
      w_addr      = '0;
      w_wdata     = '0;
      tx_ready_o  = 1'b0;
      job_ready_o = 1'b0;
      done_o      = 1'b0;
      error_o     = 1'b0;
      case (r_state)
         ST_IDLE:      job_ready_o = ~preset_i;
         ST_CFG_PRESC: begin
            w_start = 1'b1;
            w_write = 1'b1;
            w_addr  = ADDR_WIDTH'(c_reg_prescale);
            w_wdata = DATA_WIDTH'(r_presc);
         end
         ST_CFG_ADDR: begin
            w_start = 1'b1;
            w_write = 1'b1;
            w_addr  = ADDR_WIDTH'(c_reg_slave_addr);
            w_wdata = DATA_WIDTH'({r_addr, r_rw});
         end
         ST_WAIT_TX:   tx_ready_o = ~preset_i;
         ST_WR_DATA: begin
            w_start = 1'b1;
            w_write = 1'b1;
            w_addr  = ADDR_WIDTH'(c_reg_transmit);
            w_wdata = DATA_WIDTH'(r_tx_byte);
         end
         ST_WR_CMD: begin
            w_start = 1'b1;
            w_write = 1'b1;
            w_addr  = ADDR_WIDTH'(c_reg_command);
            w_wdata = DATA_WIDTH'(make_cmd(w_last, r_rw));
         end
         ST_POLL: begin
            w_start = 1'b1;
            w_addr  = ADDR_WIDTH'(c_reg_status);
         end
         ST_RD_DATA: begin
            w_start = 1'b1;
            w_addr  = ADDR_WIDTH'(c_reg_receive);
         end
         ST_DONE: begin
            done_o  = ~preset_i;
            error_o = ~preset_i & r_err;
         end
         default: ;
      endcase
   end

   assign rx_valid_o = r_rx_valid;
   assign rx_data_o  = r_rx_data;

endmodule
`default_nettype wire

// File: tb/tb_i2c_apb_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_apb_sequencer
//  Description : Directed self-checking bench for i2c_apb_sequencer with a
//                behavioural APB slave (configurable wait states, STATUS and
//                RECEIVE responses, transfer log).
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_apb_sequencer;

   logic       pclk = 1'b0;
   logic       preset;
   logic       job_valid;
   logic       job_ready;
   logic       job_rw;
   logic [6:0] job_addr;
   logic [7:0] job_presc;
   logic [3:0] job_len;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] tx_data;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       done;
   logic       error;
   logic [7:0] paddr;
   logic       pwrite;
   logic       psel;
   logic       penable;
   logic [7:0] pwdata;
   logic [7:0] prdata = 8'h00;
   logic       pready = 1'b0;

   always #5 pclk = ~pclk;

   i2c_apb_sequencer #(
      .ADDR_WIDTH (8),
      .DATA_WIDTH (8),
      .LEN_WIDTH  (4),
      .POLL_MAX   (4)
   ) dut (
      .pclk_i         (pclk),
      .preset_i       (preset),
      .job_valid_i    (job_valid),
      .job_ready_o    (job_ready),
      .job_rw_i       (job_rw),
      .job_addr_i     (job_addr),
      .job_prescale_i (job_presc),
      .job_len_i      (job_len),
      .tx_valid_i     (tx_valid),
      .tx_ready_o     (tx_ready),
      .tx_data_i      (tx_data),
      .rx_valid_o     (rx_valid),
      .rx_data_o      (rx_data),
      .done_o         (done),
      .error_o        (error),
      .paddr_o        (paddr),
      .pwrite_o       (pwrite),
      .psel_o         (psel),
      .penable_o      (penable),
      .pwdata_o       (pwdata),
      .prdata_i       (prdata),
      .pready_i       (pready)
   );

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ------------------------------------------------------------ APB slave
   logic [7:0]  stat_val    = 8'h00;
   int          wait_states = 0;
   logic [7:0]  rxd [0:7];
   int          rx_i        = 0;
   logic [16:0] log_e [0:127];
   int          log_n       = 0;
   int          n_unstable  = 0;
   int          wcnt        = 0;
   logic [7:0]  s_addr;
   logic        s_wr;
   logic [7:0]  s_wd;

   always @(negedge pclk) begin
      pready = 1'b0;
      if (psel && !penable) begin
         wcnt   = 0;
         s_addr = paddr;
         s_wr   = pwrite;
         s_wd   = pwdata;
      end else if (psel && penable) begin
         if (paddr !== s_addr || pwrite !== s_wr || pwdata !== s_wd) n_unstable++;
         if (wcnt >= wait_states) begin
            pready = 1'b1;
            prdata = 8'h00;
            if (!pwrite && paddr == 8'h05) begin
               prdata = stat_val;
            end else if (!pwrite && paddr == 8'h01) begin
               prdata = rxd[rx_i[2:0]];
               rx_i++;
            end
            if (log_n < 128) log_e[log_n] = {pwrite, paddr, pwrite ? pwdata : 8'h00};
            log_n++;
         end else begin
            wcnt++;
         end
      end
   end

   // --------------------------------------------------------- job driver
   logic [7:0]  txb [0:7];
   logic [16:0] expq [0:15];
   int          exp_n;
   logic [7:0]  rxq [0:7];
   int          n_rx, n_done, n_hs, n_txrdy, job_cycles;
   logic        done_err;

   function automatic logic [16:0] enc(input logic w, input logic [7:0] a, input logic [7:0] d);
      return {w, a, d};
   endfunction

   task automatic run_job(input logic rw, input logic [6:0] a, input logic [7:0] p,
                          input logic [3:0] len, input int maxc);
      int  ti;
      int  post;
      logic hs_prev;
      logic got_done;
      n_rx = 0; n_done = 0; n_hs = 0; n_txrdy = 0; job_cycles = 0; done_err = 1'b0;
      ti = 0; post = 0; hs_prev = 1'b0; got_done = 1'b0;
      job_rw = rw; job_addr = a; job_presc = p; job_len = len;
      job_valid = 1'b1;
      @(negedge pclk);
      job_valid = 1'b0;
      chk("accept_setup", {30'd0, psel, penable}, 32'h2);
      for (int c = 0; c < maxc && !(got_done && post >= 3); c++) begin
         if (hs_prev) ti++;
         tx_valid = (rw == 1'b0) && (ti < int'(len));
         tx_data  = txb[ti[2:0]];
         hs_prev  = tx_valid && tx_ready;
         if (tx_ready) n_txrdy++;
         if (hs_prev)  n_hs++;
         if (rx_valid) begin
            rxq[n_rx[2:0]] = rx_data;
            n_rx++;
         end
         if (done) begin
            n_done++;
            done_err   = error;
            job_cycles = c + 1;
            got_done   = 1'b1;
         end else if (got_done) begin
            post++;
         end
         @(negedge pclk);
      end
      tx_valid = 1'b0;
      chk("job_done_in_budget", {31'd0, got_done}, 32'd1);
   endtask

   task automatic chk_seq(input string tag, input int base);
      chk({tag, "_count"}, log_n - base, exp_n);
      for (int k = 0; k < exp_n; k++)
         chk($sformatf("%s_xfer%0d", tag, k), {15'd0, log_e[base + k]}, {15'd0, expq[k]});
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int  base;
      int  l0;
      int  l1;
      int  nd;
      logic found;

      rxd[0] = 8'h11; rxd[1] = 8'h22; rxd[2] = 8'h33; rxd[3] = 8'h44;
      rxd[4] = 8'h55; rxd[5] = 8'h66; rxd[6] = 8'h77; rxd[7] = 8'h88;
      preset = 1'b1; job_valid = 1'b0; job_rw = 1'b0; job_addr = '0;
      job_presc = '0; job_len = '0; tx_valid = 1'b0; tx_data = '0;

      // ---------------- reset values
      @(negedge pclk);
      @(negedge pclk);
      chk("rst_job_ready", {31'd0, job_ready}, 32'd0);
      chk("rst_psel",      {31'd0, psel}, 32'd0);
      chk("rst_penable",   {31'd0, penable}, 32'd0);
      chk("rst_done",      {31'd0, done}, 32'd0);
      chk("rst_tx_ready",  {31'd0, tx_ready}, 32'd0);
      chk("rst_rx_valid",  {31'd0, rx_valid}, 32'd0);
      chk("rst_paddr",     {24'd0, paddr}, 32'd0);
      chk("rst_pwdata",    {24'd0, pwdata}, 32'd0);
      preset = 1'b0;
      @(negedge pclk);
      chk("post_rst_job_ready", {31'd0, job_ready}, 32'd1);

      // ---------------- write job, len=2
      txb[0] = 8'hA5; txb[1] = 8'h3C;
      base = log_n;
      run_job(1'b0, 7'h50, 8'd10, 4'd2, 100);
      expq[0] = enc(1, 8'h04, 8'h0A); expq[1] = enc(1, 8'h02, 8'hA0);
      expq[2] = enc(1, 8'h00, 8'hA5); expq[3] = enc(1, 8'h03, 8'h01);
      expq[4] = enc(0, 8'h05, 8'h00); expq[5] = enc(1, 8'h00, 8'h3C);
      expq[6] = enc(1, 8'h03, 8'h05); expq[7] = enc(0, 8'h05, 8'h00);
      exp_n = 8;
      chk_seq("wr2", base);
      chk("wr2_done_count", n_done, 1);
      chk("wr2_error", {31'd0, done_err}, 32'd0);
      chk("wr2_tx_bytes", n_hs, 2);

      // ---------------- read job, len=3
      base = log_n;
      run_job(1'b1, 7'h21, 8'h05, 4'd3, 100);
      expq[0]  = enc(1, 8'h04, 8'h05); expq[1]  = enc(1, 8'h02, 8'h43);
      expq[2]  = enc(1, 8'h03, 8'h03); expq[3]  = enc(0, 8'h05, 8'h00);
      expq[4]  = enc(0, 8'h01, 8'h00); expq[5]  = enc(1, 8'h03, 8'h03);
      expq[6]  = enc(0, 8'h05, 8'h00); expq[7]  = enc(0, 8'h01, 8'h00);
      expq[8]  = enc(1, 8'h03, 8'h07); expq[9]  = enc(0, 8'h05, 8'h00);
      expq[10] = enc(0, 8'h01, 8'h00);
      exp_n = 11;
      chk_seq("rd3", base);
      chk("rd3_rx_count", n_rx, 3);
      chk("rd3_rx0", {24'd0, rxq[0]}, 32'h11);
      chk("rd3_rx1", {24'd0, rxq[1]}, 32'h22);
      chk("rd3_rx2", {24'd0, rxq[2]}, 32'h33);
      chk("rd3_done_count", n_done, 1);
      chk("rd3_error", {31'd0, done_err}, 32'd0);
      chk("rd3_no_tx_ready", n_txrdy, 0);

      // ---------------- wait states: 3 extra cycles per transfer (5 transfers)
      txb[0] = 8'hA5;
      run_job(1'b0, 7'h50, 8'd10, 4'd1, 100);
      l0 = job_cycles;
      wait_states = 3;
      base = log_n;
      run_job(1'b0, 7'h50, 8'd10, 4'd1, 150);
      l1 = job_cycles;
      wait_states = 0;
      chk("wait_extra_cycles", l1 - l0, 15);
      expq[0] = enc(1, 8'h04, 8'h0A); expq[1] = enc(1, 8'h02, 8'hA0);
      expq[2] = enc(1, 8'h00, 8'hA5); expq[3] = enc(1, 8'h03, 8'h05);
      expq[4] = enc(0, 8'h05, 8'h00);
      exp_n = 5;
      chk_seq("wait", base);
      chk("wait_stable", n_unstable, 0);
      chk("wait_error", {31'd0, done_err}, 32'd0);

      // ---------------- NACK after first byte of a len=3 write
      stat_val = 8'h40;
      txb[0] = 8'h11; txb[1] = 8'h22; txb[2] = 8'h33;
      base = log_n;
      run_job(1'b0, 7'h10, 8'h02, 4'd3, 100);
      expq[0] = enc(1, 8'h04, 8'h02); expq[1] = enc(1, 8'h02, 8'h20);
      expq[2] = enc(1, 8'h00, 8'h11); expq[3] = enc(1, 8'h03, 8'h01);
      expq[4] = enc(0, 8'h05, 8'h00);
      exp_n = 5;
      chk_seq("nack", base);
      chk("nack_tx_ready_cycles", n_txrdy, 1);
      chk("nack_done_count", n_done, 1);
      chk("nack_error", {31'd0, done_err}, 32'd1);

      // ---------------- STATUS stuck busy, POLL_MAX=4
      stat_val = 8'h80;
      txb[0] = 8'hA5;
      base = log_n;
      run_job(1'b0, 7'h50, 8'd10, 4'd1, 100);
      expq[0] = enc(1, 8'h04, 8'h0A); expq[1] = enc(1, 8'h02, 8'hA0);
      expq[2] = enc(1, 8'h00, 8'hA5); expq[3] = enc(1, 8'h03, 8'h05);
      expq[4] = enc(0, 8'h05, 8'h00); expq[5] = enc(0, 8'h05, 8'h00);
      expq[6] = enc(0, 8'h05, 8'h00); expq[7] = enc(0, 8'h05, 8'h00);
      exp_n = 8;
      chk_seq("busy", base);
      chk("busy_error", {31'd0, done_err}, 32'd1);
      stat_val = 8'h00;

      // ---------------- reset during ACCESS of WR_CMD
      job_rw = 1'b0; job_addr = 7'h50; job_presc = 8'h01; job_len = 4'd2;
      tx_valid = 1'b1; tx_data = 8'hA5;
      job_valid = 1'b1;
      @(negedge pclk);
      job_valid = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         if (psel && penable && paddr == 8'h03) found = 1'b1;
         else @(negedge pclk);
      end
      chk("rstmid_reached_cmd", {31'd0, found}, 32'd1);
      preset = 1'b1;
      @(negedge pclk);
      chk("rstmid_psel", {31'd0, psel}, 32'd0);
      chk("rstmid_job_ready_in_reset", {31'd0, job_ready}, 32'd0);
      preset = 1'b0;
      tx_valid = 1'b0;
      nd = 0;
      @(negedge pclk);
      chk("rstmid_job_ready", {31'd0, job_ready}, 32'd1);
      for (int c = 0; c < 3; c++) begin
         if (done) nd++;
         @(negedge pclk);
      end
      chk("rstmid_no_done", nd, 0);

      base = log_n;
      run_job(1'b1, 7'h2A, 8'h33, 4'd0, 50);
      expq[0] = enc(1, 8'h04, 8'h33); expq[1] = enc(1, 8'h02, 8'h55);
      exp_n = 2;
      chk_seq("len0", base);
      chk("len0_done_count", n_done, 1);
      chk("len0_error", {31'd0, done_err}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
